ram_loader: RTL and testbench

Boot loader that sits directly upstream of the computer's word RAM. It receives a framed byte stream from the serial receiver, assembles big-endian 16-bit words and writes them to consecutive RAM addresses starting at 0. It holds the CPU in reset until a complete frame with a valid checksum has been written. It replaces preloading memory from the testbench: the bench drives bytes, and the CPU starts only after `cpu_run` rises.

---
 rtl/loader_pkg.sv | 18 +
 rtl/ram_loader.sv | 129 ++++++++++++
 tb/tb_ram_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the default frame-start byte.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/ram_loader.sv
// Boot loader: parses a framed byte stream into big-endian words, writes them to RAM from
// address 0 and releases the CPU only after a frame with a good checksum has been stored.
module ram_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter int         DATA_W = 16,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              clock_50_b7a,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  // Handshake: a byte moves when rx_valid && rx_ready at a rising edge; rx_ready is
  // registered and only drops for the single WRITE cycle of each word.

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       len;
  logic [ADDR_W:0]   idx;
  logic [7:0]        acc;
  logic [7:0]        hi;

  logic              accept;
  logic [ADDR_W:0]   idx_inc;
  logic [7:0]        acc_sum;
  logic [15:0]       len_full;

  assign accept   = rx_valid && rx_ready;
  assign idx_inc  = idx + 1'b1;
  assign acc_sum  = acc + rx_data;
  assign len_full = {len[15:8], rx_data};

  always_ff @(posedge clock_50_b7a or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      acc       <= '0;
      hi        <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      rx_ready <= 1'b1;
      case (state)
        S_WRITE: begin
          // The index is one bit wider than the address, so a full-RAM frame ends cleanly.
          idx <= idx_inc;
          if (32'(idx_inc) == 32'(len)) state <= S_CHK;
          else                          state <= S_DATA_HI;
        end
        default: begin
          if (accept) begin
            case (state)
              S_IDLE, S_DONE, S_ERR: begin
                if (rx_data == SYNC) begin
                  state   <= S_LEN_HI;
                  acc     <= '0;
                  idx     <= '0;
                  done    <= 1'b0;
                  error   <= 1'b0;
                  cpu_run <= 1'b0;
                end
              end
              S_LEN_HI: begin
                len[15:8] <= rx_data;
                acc       <= acc_sum;
                state     <= S_LEN_LO;
              end
              S_LEN_LO: begin
                len[7:0] <= rx_data;
                acc      <= acc_sum;
                if ({1'b0, len_full} > CAPACITY) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else if (len_full == 16'd0) begin
                  state <= S_CHK;
                end else begin
                  state <= S_DATA_HI;
                end
              end
              S_DATA_HI: begin
                hi    <= rx_data;
                acc   <= acc_sum;
                state <= S_DATA_LO;
              end
              S_DATA_LO: begin
                acc       <= acc_sum;
                mem_we    <= 1'b1;
                mem_addr  <= idx[ADDR_W-1:0];
                mem_wdata <= DATA_W'({hi, rx_data});
                rx_ready  <= 1'b0;
                state     <= S_WRITE;
              end
              S_CHK: begin
                if (acc_sum == 8'd0) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  cpu_run <= 1'b1;
                end else begin
                  state <= S_ERR;
                  error <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: drives framed byte streams and checks RAM writes,
// status outputs, handshake timing and asynchronous reset behaviour.
module tb_ram_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_run;
  logic              done;
  logic              error;

  ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC(8'hA5)) dut (
    .clock_50_b7a (clk),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .done         (done),
    .error        (error)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int t_sync;
  logic mon_en = 1'b0;
  int low_cnt = 0;
  int disagree = 0;

  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [15:0] ram [0:255];
  logic [7:0]  fr[$];

  always @(posedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      ram[mem_addr] = mem_wdata;
    end
    if (rx_valid && rx_ready) last_acc = cyc;
    if (mon_en) begin
      if (!rx_ready) low_cnt++;
      if (rx_ready == mem_we) disagree++;
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
    wr_q.delete();
    exp_q.delete();
  endtask

  // drivers: entered and left on a falling edge, so consecutive calls keep rx_valid high
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 16) begin
      check("accept_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_run"},   32'(cpu_run),   32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] wlo;
    logic [7:0] whi;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(rx_ready), 32'd1);

    // Good 3-word frame at full rate. Sum after SYNC = 0xC2, so CHK = 0x3E.
    exp_q.push_back({8'd0, 16'h1234});
    exp_q.push_back({8'd1, 16'hABCD});
    exp_q.push_back({8'd2, 16'h0001});
    low_cnt  = 0;
    disagree = 0;
    mon_en   = 1'b1;
    send_byte(8'hA5);
    t_sync = last_acc;
    fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h3E};
    send_frame(fr);
    mon_en = 1'b0;
    check("good_cycles", 32'(last_acc - t_sync), 32'd12);
    check("good_ready_low", 32'(low_cnt), 32'd3);
    check("good_ready_vs_we", 32'(disagree), 32'd0);
    check_writes("good");
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_run", 32'(cpu_run), 32'd1);
    check("good_error", 32'(error), 32'd0);
    check("good_addr_hold", 32'(mem_addr), 32'd2);
    check("good_wdata_hold", 32'(mem_wdata), 32'h0001);

    // Same frame with a bad checksum, restarted from DONE by SYNC
    exp_q.push_back({8'd0, 16'h1234});
    exp_q.push_back({8'd1, 16'hABCD});
    exp_q.push_back({8'd2, 16'h0001});
    send_byte(8'hA5);
    check("restart_done_clear", 32'(done), 32'd0);
    check("restart_cpu_hold", 32'(cpu_run), 32'd0);
    fr = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h00};
    send_frame(fr);
    check_writes("badchk");
    check("badchk_error", 32'(error), 32'd1);
    check("badchk_done", 32'(done), 32'd0);
    check("badchk_cpu_run", 32'(cpu_run), 32'd0);

    // Junk bytes are discarded, then an empty frame loads
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(fr);
    check("junk_error_kept", 32'(error), 32'd1);
    check("junk_done", 32'(done), 32'd0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(fr);
    check_writes("len0");
    check("len0_done", 32'(done), 32'd1);
    check("len0_cpu_run", 32'(cpu_run), 32'd1);
    check("len0_error", 32'(error), 32'd0);

    // Oversize LEN = 0x0101 fails on the LEN_LO byte
    fr = '{8'hA5, 8'h01, 8'h01};
    send_frame(fr);
    check("over_error", 32'(error), 32'd1);
    check("over_done", 32'(done), 32'd0);
    check("over_cpu_run", 32'(cpu_run), 32'd0);
    fr = '{8'h12, 8'h34};
    send_frame(fr);
    check_writes("over");
    check("over_error_kept", 32'(error), 32'd1);

    // LEN = 0x0100 exactly fills the RAM
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    sum = 8'h01;
    for (int i = 0; i < 256; i++) begin
      wlo = 8'(i);
      whi = wlo ^ 8'h5A;
      exp_q.push_back({wlo, whi, wlo});
      sum = sum + whi + wlo;
      send_byte(whi);
      send_byte(wlo);
    end
    send_byte(8'h00 - sum);
    check_writes("full");
    check("full_done", 32'(done), 32'd1);
    check("full_error", 32'(error), 32'd0);
    check("full_last_addr", 32'(mem_addr), 32'hFF);

    // Reset after the second data word; CHK for BEEF CAFE 0042 is 0x46
    exp_q.push_back({8'd0, 16'hBEEF});
    exp_q.push_back({8'd1, 16'hCAFE});
    fr = '{8'hA5, 8'h00, 8'h03, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
    send_frame(fr);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check_writes("midreset");
    check("midreset_ram0", 32'(ram[0]), 32'hBEEF);
    check("midreset_ram1", 32'(ram[1]), 32'hCAFE);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({8'd0, 16'hBEEF});
    exp_q.push_back({8'd1, 16'hCAFE});
    exp_q.push_back({8'd2, 16'h0042});
    fr = '{8'hA5, 8'h00, 8'h03, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h00, 8'h42, 8'h46};
    send_frame(fr);
    check_writes("reload");
    check("reload_done", 32'(done), 32'd1);
    check("reload_cpu_run", 32'(cpu_run), 32'd1);
    check("reload_ram2", 32'(ram[2]), 32'h0042);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
